mem_trace_arbiter: RTL and testbench

//  Shares the single memory-trace DPI port (mem_trace_module) between NUM_REQ memory requesters
//  (default: port 0 = instruction fetch, port 1 = LSU). Round-robin grants one event per cycle

---
 rtl/mem_trace_arbiter_pkg.sv | 25 ++
 rtl/mem_trace_arbiter_if.sv | 39 +++
 rtl/mem_trace_arbiter_fifo.sv | 51 +++++
 rtl/mem_trace_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_trace_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_trace_arbiter_pkg.sv
// Shared definitions for the memory-trace arbiter: data width and the packed
// layout of one buffered trace entry {pc, data, addr, size, write, cached}.
package mem_trace_arbiter_pkg;

    localparam int unsigned DATA_LENGTH = 64;
    localparam int unsigned SIZE_W      = 3;

    localparam int unsigned OFF_CACHED  = 0;
    localparam int unsigned OFF_WRITE   = 1;
    localparam int unsigned OFF_SIZE    = 2;
    localparam int unsigned OFF_ADDR    = OFF_SIZE + SIZE_W;

    function automatic int unsigned off_data(input int unsigned dw);
        return OFF_ADDR + dw;
    endfunction

    function automatic int unsigned off_pc(input int unsigned dw);
        return OFF_ADDR + 2 * dw;
    endfunction

    function automatic int unsigned entry_w(input int unsigned dw);
        return 3 * dw + SIZE_W + 2;
    endfunction

endpackage

// File: rtl/mem_trace_arbiter_if.sv
// Requester-side and trace-sink-side signals of the memory-trace arbiter.
// The arbiter uses the slave modport; the environment drives the master modport.
interface mem_trace_arbiter_if
    import mem_trace_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DW      = DATA_LENGTH
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DW-1:0]     req_addr;
    logic [NUM_REQ*DW-1:0]     req_data;
    logic [NUM_REQ*DW-1:0]     req_pc;
    logic [NUM_REQ*SIZE_W-1:0] req_size;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_cached;

    logic                      trace_en;
    logic                      trace_req;
    logic [DW-1:0]             trace_addr;
    logic [DW-1:0]             trace_data;
    logic [DW-1:0]             trace_pc;
    logic [SIZE_W-1:0]         trace_size;
    logic                      trace_write;
    logic                      trace_cached;

    modport master (
        output req_valid, req_addr, req_data, req_pc, req_size, req_write, req_cached, trace_en,
        input  req_ready, trace_req, trace_addr, trace_data, trace_pc, trace_size,
               trace_write, trace_cached
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_pc, req_size, req_write, req_cached, trace_en,
        output req_ready, trace_req, trace_addr, trace_data, trace_pc, trace_size,
               trace_write, trace_cached
    );

endinterface

// File: rtl/mem_trace_arbiter_fifo.sv
// Generic synchronous FIFO with occupancy count; push ignored when full,
// pop ignored when empty, head entry visible combinationally on rdata.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mem_trace_arbiter.sv
// Round-robin arbiter feeding the single memory-trace port: one grant per cycle
// into a FIFO, one registered trace_req pulse per drained event, full-stall counter.
module mem_trace_arbiter
    import mem_trace_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DW      = DATA_LENGTH
) (
    input  logic               clock,
    input  logic               reset,
    mem_trace_arbiter_if.slave bus,
    output logic [31:0]        stall_cnt
);
    localparam int unsigned RRW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned EW   = entry_w(DW);
    localparam int unsigned ODAT = off_data(DW);
    localparam int unsigned OPC  = off_pc(DW);

    logic [RRW-1:0]    rr_ptr;
    logic [RRW-1:0]    grant_idx;
    logic              found;
    logic [RRW:0]      scan;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     wentry;
    logic [EW-1:0]     head;

    logic [DW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic [DW-1:0]     sel_pc;
    logic [SIZE_W-1:0] sel_size;
    logic              sel_write;
    logic              sel_cached;

    // Scan starts at rr_ptr; scan index is wrapped by subtraction so NUM_REQ need not be a power of two.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr} + (RRW + 1)'(i);
            if (scan >= (RRW + 1)'(NUM_REQ)) scan = scan - (RRW + 1)'(NUM_REQ);
            if (!found && bus.req_valid[scan[RRW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan[RRW-1:0];
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never admits a push.
    assign push = found & ~fifo_full;
    assign pop  = ~fifo_empty & bus.trace_en;

    always_comb begin
        bus.req_ready = '0;
        if (push) bus.req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_addr   = '0;
        sel_data   = '0;
        sel_pc     = '0;
        sel_size   = '0;
        sel_write  = 1'b0;
        sel_cached = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == RRW'(i)) begin
                sel_addr   = bus.req_addr[DW*i +: DW];
                sel_data   = bus.req_data[DW*i +: DW];
                sel_pc     = bus.req_pc[DW*i +: DW];
                sel_size   = bus.req_size[SIZE_W*i +: SIZE_W];
                sel_write  = bus.req_write[i];
                sel_cached = bus.req_cached[i];
            end
        end
    end

    assign wentry = {sel_pc, sel_data, sel_addr, sel_size, sel_write, sel_cached};

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant_idx == RRW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.trace_req    <= 1'b0;
            bus.trace_addr   <= '0;
            bus.trace_data   <= '0;
            bus.trace_pc     <= '0;
            bus.trace_size   <= '0;
            bus.trace_write  <= 1'b0;
            bus.trace_cached <= 1'b0;
        end else begin
            bus.trace_req <= pop;
            if (pop) begin
                bus.trace_addr   <= head[OFF_ADDR +: DW];
                bus.trace_data   <= head[ODAT +: DW];
                bus.trace_pc     <= head[OPC +: DW];
                bus.trace_size   <= head[OFF_SIZE +: SIZE_W];
                bus.trace_write  <= head[OFF_WRITE];
                bus.trace_cached <= head[OFF_CACHED];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((|bus.req_valid) && (fifo_count == CW'(DEPTH)) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_trace_arbiter.sv
// Randomized scoreboard bench for mem_trace_arbiter against a queue-based reference model.
module tb_mem_trace_arbiter;
    localparam int NR  = 2;
    localparam int DEP = 8;
    localparam int DW  = 64;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] pc;
        logic [2:0]  size;
        logic        write;
        logic        cached;
        int          tag;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] stall_cnt;

    mem_trace_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();

    mem_trace_arbiter #(.NUM_REQ(NR), .DEPTH(DEP), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    ev_t         mfifo[$];
    ev_t         expq[$];
    bit          pv[NR];
    ev_t         pev[NR];
    int          rr = 0;
    logic [31:0] exp_stall = '0;
    int          compared = 0;
    int          mismatched = 0;
    int          last_acc = -1;
    bit          started = 0;
    bit          after_reset = 0;

    function automatic ev_t rand_ev();
        ev_t e;
        e.addr   = {$urandom, $urandom};
        e.data   = {$urandom, $urandom};
        e.pc     = {$urandom, $urandom};
        e.size   = 3'($urandom_range(7));
        e.write  = 1'($urandom_range(1));
        e.cached = 1'($urandom_range(1));
        e.tag    = 0;
        return e;
    endfunction

    // One clock of stimulus; the reference model decides acceptance and drain order.
    task automatic step(input bit rst, input bit en);
        int          g;
        int          p;
        bit          full;
        logic [NR-1:0] exp_ready;
        ev_t         ev;
        @(negedge clock);
        #1;
        if (started) begin
            compared++;
            if (stall_cnt !== exp_stall) begin
                mismatched++;
                $display("FAIL stall_cnt cyc=%0d got=%0d expected=%0d", cyc, stall_cnt, exp_stall);
            end
        end
        if (after_reset) begin
            after_reset = 0;
            compared++;
            if (bus.trace_req !== 1'b0 || bus.trace_addr !== '0 || bus.trace_data !== '0 ||
                bus.trace_pc !== '0 || bus.trace_size !== '0 || bus.trace_write !== 1'b0 ||
                bus.trace_cached !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_outputs got req=%b addr=%h data=%h pc=%h size=%0d w=%b c=%b expected all zero",
                         bus.trace_req, bus.trace_addr, bus.trace_data, bus.trace_pc,
                         bus.trace_size, bus.trace_write, bus.trace_cached);
            end
        end
        reset        = rst;
        bus.trace_en = en;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]         = pv[i] & ~rst;
            bus.req_addr[DW*i +: DW] = pev[i].addr;
            bus.req_data[DW*i +: DW] = pev[i].data;
            bus.req_pc[DW*i +: DW]   = pev[i].pc;
            bus.req_size[3*i +: 3]   = pev[i].size;
            bus.req_write[i]         = pev[i].write;
            bus.req_cached[i]        = pev[i].cached;
        end
        #1;
        last_acc = -1;
        if (rst) begin
            mfifo.delete();
            expq.delete();
            rr          = 0;
            exp_stall   = '0;
            started     = 1;
            after_reset = 1;
        end else begin
            full = (mfifo.size() >= DEP);
            g = -1;
            for (int k = 0; k < NR; k++) begin
                p = (rr + k) % NR;
                if (g < 0 && pv[p]) g = p;
            end
            exp_ready = '0;
            if (g >= 0 && !full) exp_ready[g] = 1'b1;
            compared++;
            if (bus.req_ready !== exp_ready) begin
                mismatched++;
                $display("FAIL req_ready cyc=%0d got=%b expected=%b", cyc, bus.req_ready, exp_ready);
            end
            if (full && (pv[0] || pv[1]) && exp_stall != '1) exp_stall = exp_stall + 1;
            if (mfifo.size() > 0 && en) begin
                ev     = mfifo.pop_front();
                ev.tag = cyc + 1;
                expq.push_back(ev);
            end
            if (exp_ready != '0) begin
                mfifo.push_back(pev[g]);
                rr       = (g + 1) % NR;
                last_acc = g;
            end
        end
    endtask

    always @(negedge clock) begin
        ev_t e;
        if (bus.trace_req === 1'b1) begin
            compared++;
            if (expq.size() == 0) begin
                mismatched++;
                $display("FAIL trace_unexpected cyc=%0d got addr=%h expected no pulse", cyc, bus.trace_addr);
            end else begin
                e = expq.pop_front();
                if (e.tag != cyc || bus.trace_addr !== e.addr || bus.trace_data !== e.data ||
                    bus.trace_pc !== e.pc || bus.trace_size !== e.size ||
                    bus.trace_write !== e.write || bus.trace_cached !== e.cached) begin
                    mismatched++;
                    $display("FAIL trace_event got cyc=%0d addr=%h data=%h pc=%h size=%0d w=%b c=%b expected cyc=%0d addr=%h data=%h pc=%h size=%0d w=%b c=%b",
                             cyc, bus.trace_addr, bus.trace_data, bus.trace_pc, bus.trace_size,
                             bus.trace_write, bus.trace_cached, e.tag, e.addr, e.data, e.pc,
                             e.size, e.write, e.cached);
                end
            end
        end else if (expq.size() > 0 && expq[0].tag <= cyc) begin
            compared++;
            mismatched++;
            $display("FAIL trace_missing cyc=%0d got no pulse expected addr=%h at cyc=%0d",
                     cyc, expq[0].addr, expq[0].tag);
            void'(expq.pop_front());
        end
    end

    task automatic run_random(input int n, input int pct0, input int pct1, input int en_pct);
        int pct[NR];
        pct[0] = pct0;
        pct[1] = pct1;
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < NR; p++) begin
                if (!pv[p] && $urandom_range(99) < pct[p]) begin
                    pv[p]  = 1;
                    pev[p] = rand_ev();
                end
            end
            step(0, $urandom_range(99) < en_pct);
            if (last_acc >= 0) pv[last_acc] = 0;
        end
    endtask

    task automatic idle(input int n, input bit en);
        pv[0] = 0;
        pv[1] = 0;
        for (int c = 0; c < n; c++) step(0, en);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    initial begin
        #200000;
        mismatched++;
        $display("FAIL timeout got no completion expected finish before 200000");
        summary();
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_pc     = '0;
        bus.req_size   = '0;
        bus.req_write  = '0;
        bus.req_cached = '0;
        bus.trace_en   = 1'b0;
        for (int p = 0; p < NR; p++) begin
            pv[p]  = 0;
            pev[p] = rand_ev();
        end
        step(1, 0);
        step(1, 0);

        // Single directed event on port 0 into an empty FIFO.
        pev[0].addr   = 64'h0000_0000_8000_0010;
        pev[0].write  = 1'b1;
        pev[0].size   = 3'd3;
        pev[0].cached = 1'b1;
        pv[0] = 1;
        step(0, 1);
        idle(4, 1);

        // Both ports valid every cycle with draining enabled.
        run_random(8, 100, 100, 100);
        idle(4, 1);

        // Port 1 sends 10 events with draining frozen, then drains.
        sent = 0;
        pv[1]  = 1;
        pev[1] = rand_ev();
        for (int c = 0; c < 44; c++) begin
            step(0, c >= 14);
            if (last_acc == 1) begin
                sent++;
                if (sent < 10) pev[1] = rand_ev();
                else pv[1] = 0;
            end
        end
        idle(4, 1);

        // Fill to full, then drain while both ports stay valid.
        run_random(10, 100, 100, 0);
        run_random(16, 100, 100, 100);
        idle(10, 1);

        // Buffer 5 events, then reset mid-operation.
        sent = 0;
        for (int c = 0; c < 10 && sent < 5; c++) begin
            if (!pv[0]) begin
                pv[0]  = 1;
                pev[0] = rand_ev();
            end
            step(0, 0);
            if (last_acc == 0) begin
                sent++;
                pv[0] = 0;
            end
        end
        pv[0] = 0;
        pv[1] = 0;
        step(1, 0);
        idle(6, 1);

        // Port 1 alone, repeatedly granted after wrap of rr_ptr.
        run_random(6, 0, 100, 100);
        idle(3, 1);

        for (int ph = 0; ph < 6; ph++) begin
            run_random(60, $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(0, 100));
        end
        idle(14, 1);

        compared++;
        if (expq.size() != 0 || mfifo.size() != 0) begin
            mismatched++;
            $display("FAIL leftover got pending=%0d buffered=%0d expected 0/0", expq.size(), mfifo.size());
        end
        summary();
        $finish;
    end

endmodule
